unified_mem_arbiter: RTL and testbench

- Shares one single-port, fixed-latency RAM between two requesters: the IF stage (instruction reads) and the MEM stage (data loads/stores).
- Sits between the pipeline stages and the unified RAM.
- Each requester sees a REQ/DONE handshake. The pipeline stalls its stage while REQ is high and DONE is low.
- Grants, drives the RAM for MEM_LAT cycles, captures read data, and returns DONE.

---
 rtl/unified_mem_arbiter_pkg.sv | 19 +
 rtl/unified_mem_arbiter_pick.sv | 30 +++
 rtl/unified_mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified IF/MEM RAM arbiter.
// Optional build macro: ARB_ROUND_ROBIN_EN.
package unified_mem_arbiter_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_e;

   localparam logic [3:0] CTRL_WORD   = 4'b0010;
   localparam int         MEM_LAT_DEF = 2;
   localparam int         CNT_W       = 4;

endpackage

// File: rtl/unified_mem_arbiter_pick.sv
// Combinational grant picker for the unified RAM arbiter.
// ARB_ROUND_ROBIN_EN selects alternating grants on a tie.
module mem_arb_pick
   import unified_mem_arbiter_pkg::*;
(
   input  logic   if_elig_i,
   input  logic   d_elig_i,
`ifdef ARB_ROUND_ROBIN_EN
   input  owner_e last_i,
`endif
   output logic   gnt_o,
   output owner_e owner_o
);

   always_comb begin
      gnt_o   = if_elig_i | d_elig_i;
      owner_o = OWN_D;
      if (if_elig_i && d_elig_i) begin
`ifdef ARB_ROUND_ROBIN_EN
         owner_o = (last_i == OWN_D) ? OWN_IF : OWN_D;
`else
         // older instruction (data side) goes first
         owner_o = OWN_D;
`endif
      end else if (if_elig_i) begin
         owner_o = OWN_IF;
      end
   end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency single-port RAM between fetch and data ports.
// Build macro ARB_ROUND_ROBIN_EN enables round-robin tie breaking.
module unified_mem_arbiter
   import unified_mem_arbiter_pkg::*;
#(
   parameter int MEM_LAT = MEM_LAT_DEF,
   parameter int AW      = 8,
   parameter int DW      = 32
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          IF_REQ,
   input  logic [AW-1:0] IF_ADDR,
   output logic [DW-1:0] IF_RDATA,
   output logic          IF_DONE,
   input  logic          D_REQ,
   input  logic          D_WE,
   input  logic [AW-1:0] D_ADDR,
   input  logic [3:0]    D_CTRL,
   input  logic [DW-1:0] D_WDATA,
   output logic [DW-1:0] D_RDATA,
   output logic          D_DONE,
   output logic          RAM_EN,
   output logic          RAM_WE,
   output logic [AW-1:0] RAM_ADDR,
   output logic [3:0]    RAM_CTRL,
   output logic [DW-1:0] RAM_WDATA,
   input  logic [DW-1:0] RAM_RDATA
);

   state_e             state_q, state_d;
   owner_e             owner_q, owner_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ram_en_q, ram_en_d;
   logic               ram_we_q, ram_we_d;
   logic [AW-1:0]      ram_addr_q, ram_addr_d;
   logic [3:0]         ram_ctrl_q, ram_ctrl_d;
   logic [DW-1:0]      ram_wdata_q, ram_wdata_d;
   logic [DW-1:0]      if_rdata_q, if_rdata_d;
   logic [DW-1:0]      d_rdata_q, d_rdata_d;
   logic               if_done_q, if_done_d;
   logic               d_done_q, d_done_d;
   logic               gnt;
   owner_e             gnt_owner;

   // a port is blocked during its own DONE so it can drop REQ cleanly
   wire if_elig = IF_REQ & ~if_done_q;
   wire d_elig  = D_REQ & ~d_done_q;

`ifdef ARB_ROUND_ROBIN_EN
   owner_e last_q, last_d;

   mem_arb_pick u_pick (
      .if_elig_i (if_elig),
      .d_elig_i  (d_elig),
      .last_i    (last_q),
      .gnt_o     (gnt),
      .owner_o   (gnt_owner)
   );

   always_comb begin
      last_d = last_q;
      if (state_q == ST_IDLE && gnt) last_d = gnt_owner;
   end

   always_ff @(posedge CLK) begin
      if (RST) last_q <= OWN_D;
      else     last_q <= last_d;
   end
`else
   mem_arb_pick u_pick (
      .if_elig_i (if_elig),
      .d_elig_i  (d_elig),
      .gnt_o     (gnt),
      .owner_o   (gnt_owner)
   );
`endif

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      ram_en_d    = ram_en_q;
      ram_we_d    = ram_we_q;
      ram_addr_d  = ram_addr_q;
      ram_ctrl_d  = ram_ctrl_q;
      ram_wdata_d = ram_wdata_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      if_done_d   = 1'b0;
      d_done_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (gnt) begin
               owner_d  = gnt_owner;
               cnt_d    = CNT_W'(MEM_LAT - 1);
               ram_en_d = 1'b1;
               state_d  = ST_ACCESS;
               if (gnt_owner == OWN_D) begin
                  ram_we_d    = D_WE;
                  ram_addr_d  = D_ADDR;
                  ram_ctrl_d  = D_CTRL;
                  ram_wdata_d = D_WDATA;
               end else begin
                  ram_we_d    = 1'b0;
                  ram_addr_d  = IF_ADDR;
                  ram_ctrl_d  = CTRL_WORD;
                  ram_wdata_d = '0;
               end
            end
         end
         ST_ACCESS: begin
            if (cnt_q == '0) begin
               ram_en_d = 1'b0;
               ram_we_d = 1'b0;
               state_d  = ST_IDLE;
               if (owner_q == OWN_D) begin
                  d_done_d = 1'b1;
                  if (!ram_we_q) d_rdata_d = RAM_RDATA;
               end else begin
                  if_done_d  = 1'b1;
                  if_rdata_d = RAM_RDATA;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWN_D;
         cnt_q       <= '0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_ctrl_q  <= '0;
         ram_wdata_q <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         if_done_q   <= 1'b0;
         d_done_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_ctrl_q  <= ram_ctrl_d;
         ram_wdata_q <= ram_wdata_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         if_done_q   <= if_done_d;
         d_done_q    <= d_done_d;
      end
   end

   assign IF_RDATA  = if_rdata_q;
   assign IF_DONE   = if_done_q;
   assign D_RDATA   = d_rdata_q;
   assign D_DONE    = d_done_q;
   assign RAM_EN    = ram_en_q;
   assign RAM_WE    = ram_we_q;
   assign RAM_ADDR  = ram_addr_q;
   assign RAM_CTRL  = ram_ctrl_q;
   assign RAM_WDATA = ram_wdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter (MEM_LAT 2, plus 1 and 4 sweep).
module tb_unified_mem_arbiter;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        IF_REQ = 1'b0;
   logic [7:0]  IF_ADDR = '0;
   logic [31:0] IF_RDATA;
   logic        IF_DONE;
   logic        D_REQ = 1'b0;
   logic        D_WE = 1'b0;
   logic [7:0]  D_ADDR = '0;
   logic [3:0]  D_CTRL = '0;
   logic [31:0] D_WDATA = '0;
   logic [31:0] D_RDATA;
   logic        D_DONE;
   logic        RAM_EN, RAM_WE;
   logic [7:0]  RAM_ADDR;
   logic [3:0]  RAM_CTRL;
   logic [31:0] RAM_WDATA, RAM_RDATA;

   logic        req1 = 1'b0, req4 = 1'b0;
   logic        zero1 = 1'b0;
   logic [3:0]  zero4 = '0;
   logic [31:0] zero32 = '0;
   logic [31:0] ifr1, ifr4, dr1, dr4, wd1, wd4;
   logic        ifd1, ifd4, dd1, dd4, en1, en4, we1, we4;
   logic [7:0]  ad1, ad4;
   logic [3:0]  ct1, ct4;

   logic [31:0] mem [0:255];
   int          checks = 0;
   int          errors = 0;

   always #5 CLK = ~CLK;

   always @(posedge CLK)
      if (RAM_EN && RAM_WE) mem[RAM_ADDR] <= RAM_WDATA;

   function automatic logic [31:0] rd(input logic [7:0] a);
      if (a == 8'h04) return 32'hE800_0008;
      if (a == 8'h20) return 32'h1111_2222;
      return mem[a];
   endfunction

   assign RAM_RDATA = rd(RAM_ADDR);

   unified_mem_arbiter #(.MEM_LAT(2), .AW(8), .DW(32)) dut (
      .CLK(CLK), .RST(RST),
      .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR),
      .IF_RDATA(IF_RDATA), .IF_DONE(IF_DONE),
      .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR),
      .D_CTRL(D_CTRL), .D_WDATA(D_WDATA),
      .D_RDATA(D_RDATA), .D_DONE(D_DONE),
      .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR),
      .RAM_CTRL(RAM_CTRL), .RAM_WDATA(RAM_WDATA),
      .RAM_RDATA(RAM_RDATA)
   );

   unified_mem_arbiter #(.MEM_LAT(1), .AW(8), .DW(32)) dut1 (
      .CLK(CLK), .RST(RST),
      .IF_REQ(req1), .IF_ADDR(IF_ADDR),
      .IF_RDATA(ifr1), .IF_DONE(ifd1),
      .D_REQ(zero1), .D_WE(zero1), .D_ADDR(IF_ADDR),
      .D_CTRL(zero4), .D_WDATA(zero32),
      .D_RDATA(dr1), .D_DONE(dd1),
      .RAM_EN(en1), .RAM_WE(we1), .RAM_ADDR(ad1),
      .RAM_CTRL(ct1), .RAM_WDATA(wd1),
      .RAM_RDATA(rd(ad1))
   );

   unified_mem_arbiter #(.MEM_LAT(4), .AW(8), .DW(32)) dut4 (
      .CLK(CLK), .RST(RST),
      .IF_REQ(req4), .IF_ADDR(IF_ADDR),
      .IF_RDATA(ifr4), .IF_DONE(ifd4),
      .D_REQ(zero1), .D_WE(zero1), .D_ADDR(IF_ADDR),
      .D_CTRL(zero4), .D_WDATA(zero32),
      .D_RDATA(dr4), .D_DONE(dd4),
      .RAM_EN(en4), .RAM_WE(we4), .RAM_ADDR(ad4),
      .RAM_CTRL(ct4), .RAM_WDATA(wd4),
      .RAM_RDATA(rd(ad4))
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge CLK);
   endtask

   logic first_d;
   int   c1, c4, f1, f4;

   initial begin
`ifdef ARB_ROUND_ROBIN_EN
      first_d = 1'b0;
`else
      first_d = 1'b1;
`endif
      // reset and idle
      step(); step();
      RST = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle_all_zero", 32'(|{IF_RDATA, IF_DONE, D_RDATA, D_DONE,
             RAM_EN, RAM_WE, RAM_ADDR, RAM_CTRL, RAM_WDATA,
             ifr1, ifd1, en1, ifr4, ifd4, en4}), 32'd0);
      end

      // fetch read
      IF_ADDR = 8'h04; IF_REQ = 1'b1;
      for (int c = 1; c <= 2; c++) begin
         step();
         chk("fetch_en", 32'(RAM_EN), 32'd1);
         chk("fetch_addr", 32'(RAM_ADDR), 32'h04);
         chk("fetch_ctrl", 32'(RAM_CTRL), 32'h2);
         chk("fetch_we", 32'(RAM_WE), 32'd0);
         chk("fetch_early_done", 32'(IF_DONE), 32'd0);
      end
      step();
      chk("fetch_done", 32'(IF_DONE), 32'd1);
      chk("fetch_rdata", IF_RDATA, 32'hE800_0008);
      chk("fetch_en_off", 32'(RAM_EN), 32'd0);
      chk("fetch_d_done", 32'(D_DONE), 32'd0);
      IF_REQ = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("guard_no_regrant", 32'(RAM_EN), 32'd0);
         chk("guard_done_low", 32'(IF_DONE), 32'd0);
      end
      chk("fetch_rdata_held", IF_RDATA, 32'hE800_0008);

      // store
      D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 8'h10;
      D_CTRL = 4'b1010; D_WDATA = 32'hDEAD_BEEF;
      for (int c = 1; c <= 2; c++) begin
         step();
         chk("st_we", 32'(RAM_WE), 32'd1);
         chk("st_wdata", RAM_WDATA, 32'hDEAD_BEEF);
         chk("st_ctrl", 32'(RAM_CTRL), 32'hA);
         chk("st_addr", 32'(RAM_ADDR), 32'h10);
      end
      step();
      chk("st_done", 32'(D_DONE), 32'd1);
      chk("st_we_off", 32'(RAM_WE), 32'd0);
      chk("st_rdata_kept", D_RDATA, 32'd0);
      D_REQ = 1'b0; D_WE = 1'b0; D_CTRL = 4'b0010;
      step();
      chk("st_no_regrant", 32'(RAM_EN), 32'd0);

      // load back
      D_REQ = 1'b1;
      step();
      chk("ld_en", 32'(RAM_EN), 32'd1);
      chk("ld_we", 32'(RAM_WE), 32'd0);
      step();
      chk("ld_early_done", 32'(D_DONE), 32'd0);
      step();
      chk("ld_done", 32'(D_DONE), 32'd1);
      chk("ld_rdata", D_RDATA, 32'hDEAD_BEEF);
      D_REQ = 1'b0;
      step();

      // simultaneous requests
      IF_ADDR = 8'h20; IF_REQ = 1'b1; D_REQ = 1'b1;
      step();
      chk("sim_first_addr", 32'(RAM_ADDR), first_d ? 32'h10 : 32'h20);
      step();
      step();
      chk("sim_first_d_done", 32'(D_DONE), 32'(first_d));
      chk("sim_first_if_done", 32'(IF_DONE), 32'(!first_d));
      if (first_d) D_REQ = 1'b0;
      else IF_REQ = 1'b0;
      step();
      chk("sim_second_en", 32'(RAM_EN), 32'd1);
      chk("sim_second_addr", 32'(RAM_ADDR), first_d ? 32'h20 : 32'h10);
      step();
      step();
      chk("sim_second_if_done", 32'(IF_DONE), 32'(first_d));
      chk("sim_second_d_done", 32'(D_DONE), 32'(!first_d));
      chk("sim_if_rdata", IF_RDATA, 32'h1111_2222);
      IF_REQ = 1'b0; D_REQ = 1'b0;
      step();

      // reset mid-access
      IF_ADDR = 8'h04; IF_REQ = 1'b1;
      step();
      chk("rst_pre_en", 32'(RAM_EN), 32'd1);
      RST = 1'b1; IF_REQ = 1'b0;
      step();
      chk("rst_en_drop", 32'(RAM_EN), 32'd0);
      chk("rst_rdata_clr", IF_RDATA, 32'd0);
      RST = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("rst_no_done", 32'({IF_DONE, D_DONE, RAM_EN}), 32'd0);
      end

      // latency sweep on the MEM_LAT=1 and MEM_LAT=4 instances
      c1 = 0; c4 = 0; f1 = 0; f4 = 0;
      req1 = 1'b1; req4 = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         step();
         if (en1 && f1 == 0) c1++;
         if (en4 && f4 == 0) c4++;
         if (ifd1 && f1 == 0) begin f1 = c; req1 = 1'b0; end
         if (ifd4 && f4 == 0) begin f4 = c; req4 = 1'b0; end
         if (c == 5) chk("lat4_rdata", ifr4, 32'hE800_0008);
      end
      chk("lat1_en_width", 32'(c1), 32'd1);
      chk("lat1_done_cycle", 32'(f1), 32'd2);
      chk("lat4_en_width", 32'(c4), 32'd4);
      chk("lat4_done_cycle", 32'(f4), 32'd5);
      chk("lat1_rdata", ifr1, 32'hE800_0008);
      chk("lat_idle_after", 32'({en1, en4}), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
